// File: rtl/src_pingpong_buf.sv
// Double-buffered frame store: a valid-qualified pixel stream fills one bank while the
// consumer reads the other through a registered, 1-cycle-latency port.
//
// state | meaning
// IDLE  | no load in progress; waits for go with the write bank free
// LOAD  | capturing DEPTH beats into wr_bank, stalls on valid_i=0
module src_pingpong_buf #(
    parameter int WD    = 16,
    parameter int DEPTH = 784,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          valid_i,
    input  logic [WD-1:0] data_i,
    input  logic          cena,
    input  logic [AW-1:0] aa,
    input  logic          release_i,
    output logic          busy,
    output logic          ready,
    output logic          frame_avail,
    output logic          err_drop,
    output logic [WD-1:0] qa
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          wr_bank, wr_bank_nxt;
    logic          rd_bank, rd_bank_nxt;
    logic [1:0]    full, full_nxt;
    logic [AW-1:0] wr_addr, wr_addr_nxt;
    logic          ready_nxt;
    logic          err_nxt;
    logic          release_ok;
    logic          beat;
    logic          aa_in_range;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    logic [WD-1:0] mem [0:1][0:DEPTH-1];

    assign beat        = (state == LOAD) && valid_i;
    assign release_ok  = release_i && full[rd_bank];
    assign aa_in_range = (32'(aa) < DEPTH);
    assign wr_idx      = wr_addr[IW-1:0];
    assign rd_idx      = aa[IW-1:0];

    assign busy        = (state == LOAD);
    assign frame_avail = full[rd_bank];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full     <= 2'b00;
            wr_addr  <= '0;
            ready    <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_bank  <= wr_bank_nxt;
            rd_bank  <= rd_bank_nxt;
            full     <= full_nxt;
            wr_addr  <= wr_addr_nxt;
            ready    <= ready_nxt;
            err_drop <= err_nxt;
        end
    end

    // Completion and release never touch the same bank: a release needs full[rd_bank],
    // a load needs !full[wr_bank], so they only coincide when the banks differ.
    always_comb begin
        state_nxt   = state;
        wr_bank_nxt = wr_bank;
        rd_bank_nxt = rd_bank;
        full_nxt    = full;
        wr_addr_nxt = wr_addr;
        ready_nxt   = 1'b0;
        err_nxt     = 1'b0;

        if (release_ok) begin
            full_nxt[rd_bank] = 1'b0;
            rd_bank_nxt       = ~rd_bank;
        end

        case (state)
            IDLE: begin
                if (go) begin
                    if (!full[wr_bank]) begin
                        state_nxt   = LOAD;
                        wr_addr_nxt = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (go) begin
                    err_nxt = 1'b1;
                end
                if (valid_i) begin
                    if (wr_addr == LAST_ADDR) begin
                        full_nxt[wr_bank] = 1'b1;
                        wr_bank_nxt       = ~wr_bank;
                        state_nxt         = IDLE;
                        ready_nxt         = 1'b1;
                    end else begin
                        wr_addr_nxt = wr_addr + AW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Storage is never cleared; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && beat) begin
            mem[wr_bank][wr_idx] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qa <= '0;
        end else if (!cena) begin
            qa <= aa_in_range ? mem[rd_bank][rd_idx] : '0;
        end
    end

endmodule

// File: tb/tb_src_pingpong_buf.sv
// Bench for src_pingpong_buf: directed frame loads with read-back tables plus a random
// phase checked every cycle against a frame-count reference model.
module tb_src_pingpong_buf;
    localparam int WD    = 16;
    localparam int DEPTH = 784;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic          valid_i = 1'b0;
    logic [WD-1:0] data_i = '0;
    logic          cena = 1'b1;
    logic [AW-1:0] aa = '0;
    logic          release_i = 1'b0;
    logic          busy;
    logic          ready;
    logic          frame_avail;
    logic          err_drop;
    logic [WD-1:0] qa;

    always #5 clk = ~clk;

    src_pingpong_buf #(.WD(WD), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .go(go), .valid_i(valid_i), .data_i(data_i),
        .cena(cena), .aa(aa), .release_i(release_i), .busy(busy), .ready(ready),
        .frame_avail(frame_avail), .err_drop(err_drop), .qa(qa)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mchk = 1'b1;

    // Reference: banks are used in strict alternation, so the write bank is the count of
    // completed frames mod 2, the read bank the count of releases mod 2, and the number
    // of held frames is their difference.
    int            m_comp = 0;
    int            m_rel = 0;
    int            m_pix = 0;
    bit            m_loading = 1'b0;
    bit            m_ready = 1'b0;
    bit            m_err = 1'b0;
    logic [WD-1:0] m_qa = '0;
    logic [WD-1:0] m_mem [2][DEPTH];

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) m_mem[b][i] = '0;
    end

    always @(posedge clk) begin
        int            held;
        logic [WD-1:0] qa_n;
        if (rst) begin
            m_comp = 0; m_rel = 0; m_pix = 0;
            m_loading = 1'b0; m_ready = 1'b0; m_err = 1'b0; m_qa = '0;
        end else begin
            held = m_comp - m_rel;
            qa_n = m_qa;
            if (!cena) qa_n = (int'(aa) < DEPTH) ? m_mem[m_rel % 2][int'(aa)] : '0;
            m_err = go && (m_loading || held == 2);
            m_ready = 1'b0;
            if (m_loading) begin
                if (valid_i) begin
                    m_mem[m_comp % 2][m_pix] = data_i;
                    m_pix++;
                    if (m_pix == DEPTH) begin
                        m_loading = 1'b0;
                        m_comp++;
                        m_ready = 1'b1;
                    end
                end
            end else if (go && held < 2) begin
                m_loading = 1'b1;
                m_pix = 0;
            end
            if (release_i && held > 0) m_rel++;
            m_qa = qa_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mchk) begin
            checks++;
            if ({busy, ready, frame_avail, err_drop, qa} !==
                {m_loading, m_ready, (m_comp - m_rel) > 0, m_err, m_qa}) begin
                errors++;
                $display("FAIL model_cmp cyc %0d got busy=%b ready=%b avail=%b err=%b qa=%h want busy=%b ready=%b avail=%b err=%b qa=%h",
                         cyc, busy, ready, frame_avail, err_drop, qa,
                         m_loading, m_ready, (m_comp - m_rel) > 0, m_err, m_qa);
                if (errors > 30) mchk = 1'b0;
            end
        end
    endtask

    task automatic rd(input int a, output logic [WD-1:0] v);
        cena = 1'b0;
        aa = AW'(a);
        tick();
        cena = 1'b1;
        v = qa;
    endtask

    task automatic pulse_release();
        release_i = 1'b1;
        tick();
        release_i = 1'b0;
    endtask

    // Returns the cycle index (go cycle = 0) at which ready was seen.
    task automatic load_frame(input int base, input bit stall, input int midgo, output int rc);
        int k;
        int t;
        bit ph;
        bit gdone;
        k = 0; t = 0; ph = 1'b1; gdone = 1'b0;
        go = 1'b1;
        valid_i = 1'b0;
        tick();
        t = 1;
        go = 1'b0;
        chk("busy_rise", busy, 1);
        while (!ready && t < 4000) begin
            valid_i = (k < DEPTH) && (!stall || ph);
            ph = ~ph;
            data_i = WD'(base + k);
            if (midgo >= 0 && k == midgo && !gdone) begin
                go = 1'b1;
                gdone = 1'b1;
            end
            tick();
            t++;
            if (go) begin
                go = 1'b0;
                chk("midload_go_err", err_drop, 1);
                chk("midload_go_busy", busy, 1);
            end
            if (valid_i) k++;
        end
        valid_i = 1'b0;
        chk("ready_seen", ready, 1);
        chk("busy_fall", busy, 0);
        rc = t;
    endtask

    typedef struct {
        int a;
        int exp;
    } rd_vec_t;

    initial begin
        rd_vec_t       tbl[7];
        logic [WD-1:0] v;
        int            rc;

        tbl[0] = '{0, 0};
        tbl[1] = '{100, 100};
        tbl[2] = '{783, 783};
        tbl[3] = '{784, 0};
        tbl[4] = '{4095, 0};
        tbl[5] = '{1, 1};
        tbl[6] = '{500, 500};

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", {busy, ready, frame_avail, err_drop, qa}, 0);
        rst = 1'b0;
        tick();

        // basic load, then table-driven reads including out-of-range addresses
        load_frame(0, 1'b0, -1, rc);
        chk("basic_ready_cycle", rc, 785);
        chk("basic_avail", frame_avail, 1);
        tick();
        chk("ready_single_pulse", ready, 0);
        for (int i = 0; i < 7; i++) begin
            rd(tbl[i].a, v);
            chk($sformatf("basic_read_aa%0d", tbl[i].a), v, tbl[i].exp);
        end
        pulse_release();
        chk("release_clears_avail", frame_avail, 0);
        pulse_release();
        tick();
        chk("release_when_empty", {frame_avail, err_drop}, 0);

        // stalled stream
        load_frame(0, 1'b1, -1, rc);
        chk("stall_ready_cycle", (rc >= 1567 && rc <= 1569), 1);
        for (int i = 0; i < 3; i++) begin
            rd(tbl[i].a, v);
            chk($sformatf("stall_read_aa%0d", tbl[i].a), v, tbl[i].exp);
        end
        pulse_release();

        // ping-pong with both banks full, overflow and go-with-release
        load_frame(32'h1000, 1'b0, -1, rc);
        load_frame(32'h2000, 1'b0, -1, rc);
        chk("pp_avail_both_full", frame_avail, 1);
        rd(5, v);
        chk("pp_read_a5", v, 32'h1005);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("overflow_err", err_drop, 1);
        chk("overflow_busy", busy, 0);
        tick();
        chk("overflow_err_pulse", err_drop, 0);
        rd(5, v);
        chk("overflow_a_intact", v, 32'h1005);
        go = 1'b1;
        release_i = 1'b1;
        tick();
        go = 1'b0;
        release_i = 1'b0;
        chk("go_with_release_err", err_drop, 1);
        chk("go_with_release_busy", busy, 0);
        chk("pp_avail_after_release", frame_avail, 1);
        rd(5, v);
        chk("pp_read_b5", v, 32'h2005);
        rd(783, v);
        chk("pp_read_b783", v, 32'h2000 + 783);
        pulse_release();
        chk("pp_second_release", frame_avail, 0);

        // go during LOAD is dropped without disturbing the frame
        load_frame(32'h3000, 1'b0, 100, rc);
        chk("midgo_ready_cycle", rc, 785);
        rd(100, v);
        chk("midgo_read_100", v, 32'h3064);
        rd(783, v);
        chk("midgo_read_783", v, 32'h3000 + 783);
        pulse_release();

        // reset after 300 beats; partial data goes to bank 1, clean frame to bank 0
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 0; k < 300; k++) begin
            valid_i = 1'b1;
            data_i = WD'(32'h5000 + k);
            tick();
        end
        valid_i = 1'b0;
        rst = 1'b1;
        tick();
        chk("midload_reset_outputs_0", {busy, ready, frame_avail, err_drop, qa}, 0);
        tick();
        chk("midload_reset_outputs_1", {busy, ready, frame_avail, err_drop, qa}, 0);
        rst = 1'b0;
        tick();
        load_frame(32'h4000, 1'b0, -1, rc);
        chk("post_reset_ready_cycle", rc, 785);
        rd(7, v);
        chk("post_reset_read_7", v, 32'h4007);
        pulse_release();
        chk("post_reset_release", frame_avail, 0);
        rd(100, v);
        chk("stale_bank1_partial", v, 32'h5064);
        rd(500, v);
        chk("stale_bank1_old", v, 32'h2000 + 500);

        // random phase against the reference model
        for (int n = 0; n < 6000; n++) begin
            go = ($urandom_range(0, 99) < 3);
            valid_i = 1'($urandom_range(0, 1));
            data_i = WD'($urandom);
            cena = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) aa = AW'($urandom_range(DEPTH, 4095));
            else aa = AW'($urandom_range(0, DEPTH - 1));
            release_i = ($urandom_range(0, 499) == 0);
            tick();
        end
        go = 1'b0;
        valid_i = 1'b0;
        cena = 1'b1;
        release_i = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
